// File: rtl/lfsr_range_gen.sv
// Rejection-sampling front end for an lfsr32: sequences INIT/GO, keeps LFSR
// samples below a captured limit and queues them for a valid/ready consumer.
//
// state  | meaning
// IDLE   | waiting for start; FIFO contents kept
// LOAD   | lfsr_init high, seed loads into the LFSR
// STEP   | lfsr_go high, LFSR advances one step
// SAMPLE | low W bits of lfsr_q tested against limit; push or count reject
// HOLD   | FIFO full, waiting for the consumer to free an entry
module lfsr_range_gen #(
  parameter int N     = 32,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  seed_in,
  input  logic [W-1:0]  limit,
  output logic          lfsr_init,
  output logic          lfsr_go,
  output logic [N-1:0]  lfsr_seed,
  input  logic [N-1:0]  lfsr_q,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          limit_err,
  output logic [CW-1:0] reject_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_SAMPLE, S_HOLD} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  limit_q;
  logic [N-1:0]  seed_q;
  logic          stop_pend;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_after;

  logic          start_ok, flush, accept, push, pop, stop_now;
  logic [W-1:0]  cand;
  logic          unused_q_hi;

  assign cand        = lfsr_q[W-1:0];
  assign unused_q_hi = ^lfsr_q;
  assign start_ok    = start && (limit != '0);
  // A zero-limit start in IDLE only flags the error; when busy it still aborts the run.
  assign flush       = start && (start_ok || (state != S_IDLE));
  assign accept      = (state == S_SAMPLE) && (cand < limit_q);
  assign push        = accept && !flush;
  assign pop         = out_valid && out_ready && !flush;
  assign stop_now    = stop_pend || stop;
  assign count_after = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign out_valid   = (count != '0);
  assign out_data    = mem[rd_ptr];
  assign lfsr_seed   = seed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = start_ok ? S_LOAD : S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_IDLE;
        S_LOAD:   state_nxt = S_STEP;
        S_STEP:   state_nxt = S_SAMPLE;
        S_SAMPLE: state_nxt = stop_now ? S_IDLE :
                              (count_after < FULL) ? S_STEP : S_HOLD;
        // Registered count: the freed entry is seen one cycle after the pop.
        S_HOLD:   state_nxt = stop_now ? S_IDLE :
                              (count < FULL) ? S_STEP : S_HOLD;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_init = 1'b0;
    lfsr_go   = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD:   begin lfsr_init = 1'b1; busy = 1'b1; end
      S_STEP:   begin lfsr_go   = 1'b1; busy = 1'b1; end
      S_SAMPLE: busy = 1'b1;
      S_HOLD:   busy = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q    <= '0;
      seed_q     <= '0;
      limit_err  <= 1'b0;
      reject_cnt <= '0;
      stop_pend  <= 1'b0;
    end else begin
      if (start) begin
        if (start_ok) begin
          limit_err  <= 1'b0;
          limit_q    <= limit;
          seed_q     <= (seed_in == '0) ? {{(N-1){1'b0}}, 1'b1} : seed_in;
          reject_cnt <= '0;
        end else begin
          limit_err <= 1'b1;
        end
      end else if ((state == S_SAMPLE) && !accept && (reject_cnt != '1)) begin
        reject_cnt <= reject_cnt + 1'b1;
      end

      if (start || (state_nxt == S_IDLE)) begin
        stop_pend <= 1'b0;
      end else if (stop && (state != S_IDLE)) begin
        stop_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cand;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_after;
    end
  end

endmodule
